count_seq_checker: RTL and testbench
====================================

# count_seq_checker

Receiving-side monitor for the free-running N+1-bit `counter` output bus. It samples the count value, locks onto a valid +1 modulo 2^(N+1) sequence, and then flags discontinuities. It distinguishes legal wrap-around and legal upstream clears from real errors, and keeps a saturating error tally. It sits on the consumer side of any counter bus in the design and serves both as a debug/health monitor and as a self-check in benches.

## Interface
- `N`, 7: count bus is N+1 bits wide (matches `counter`).
- `LOCK_COUNT`, 4: consecutive correct increments required to declare lock (≥1).
- `ERR_W`, 8: width of the error tally.

- `clock`  in  1  single clock. All state updates on the rising edge; this samples a falling-edge-driven bus mid-cycle.
- `clear`  in  1  reset, synchronous, active-high.
- `sample_valid`  in  1  `count_in` is sampled on this edge; cycles with this low are ignored entirely.
- `count_in`  in  N+1  observed counter value.
- `locked`  out  1  high while the FSM is in LOCKED.
- `expected`  out  N+1  predicted next value: last accepted sample + 1, modulo 2^(N+1).
- `error`  out  1  one-cycle pulse on a mismatch while LOCKED.
- `wrap`  out  1  one-cycle pulse when all-ones→0 is observed while LOCKED.
- `restart`  out  1  one-cycle pulse when an upstream clear (non-max→0) is observed while LOCKED.
- `err_count`  out  ERR_W  saturating count of `error` pulses.

## Operation
- Internal registers: `prev` (N+1 bits), `run` (consecutive-match counter, sized for `LOCK_COUNT`), `miss` (1 bit), FSM state.
- "Match" means `count_in == prev + 1`, with the sum truncated to N+1 bits. The wrap from all-ones to 0 is therefore a match.
- States: ACQUIRE, TRACK, LOCKED.
- **ACQUIRE:** on a valid sample, set `prev <= count_in`, `run <= 0`, and go to TRACK.
- **TRACK:** on a valid sample:
  - Match: `run++`. If `run + 1 == LOCK_COUNT`, go to LOCKED and set `run <= 0`.
  - Non-match: `run <= 0`, stay in TRACK.
  - `error` never fires in TRACK.
- **LOCKED:** on a valid sample:
  - Match: `miss <= 0`. Also pulse `wrap` if `prev` was all-ones.
  - `count_in == 0` and not a match: pulse `restart`, `miss <= 0`, stay LOCKED. No error.
  - Any other value: pulse `error`, increment `err_count` (saturating at all-ones).
    - If `miss` is already 1 (second consecutive mismatch), go to TRACK with `run <= 0` and `miss <= 0`.
    - Otherwise set `miss <= 1` and stay LOCKED.
- `prev <= count_in` on every valid sample, in every state. The prediction always re-seeds from the latest value.
- `expected` is driven combinationally as `prev + 1` (N+1 bits). It is meaningless in ACQUIRE.
- `clear` has priority over everything, including a same-cycle `sample_valid`.

## Timing
- Reset values after a `clear` edge: state ACQUIRE, `locked` 0, `error` 0, `wrap` 0, `restart` 0, `err_count` 0, `prev` 0, `run` 0, `miss` 0. `expected` therefore reads 1.
- All flags are registered. A sample taken at edge k shows its `error`/`wrap`/`restart` pulse during the cycle after edge k, for exactly one cycle. The pulse deasserts at edge k+1 unless re-triggered.
- `locked` rises after the edge that accepts the `LOCK_COUNT`-th consecutive match.
  - Minimum: `LOCK_COUNT+1` valid samples after ACQUIRE (one seed sample plus `LOCK_COUNT` increments).
  - Default: 5 valid samples.
- `locked` falls after the edge that accepts the second consecutive mismatch. `err_count` has then advanced by 2.
- `sample_valid` low holds all state. Gaps between samples do not break the run, and no error is raised for stalls.
- Saturation: at `err_count` = 2^ERR_W−1, further errors still pulse `error` but the count holds.
- `clear` mid-lock: the FSM returns to ACQUIRE on the next edge, regardless of pending pulses. Pulses from the same edge are suppressed.

## Test plan
- **Lock and wrap** (N=7, LOCK_COUNT=4): release `clear`, then feed valid 250,251,…,255,0,1.
  - `locked` rises after sample 254.
  - `wrap` pulses exactly once, on the cycle after sample 0.
  - `error` never pulses; `err_count` = 0.
- **Single glitch:** while locked on 10,11, feed 40, then 41.
  - `error` pulses once; `err_count` = 1.
  - `locked` stays 1. Sample 41 is a match, so `miss` clears.
- **Double glitch:** while locked on 20, feed 50, then 90.
  - Two `error` pulses; `err_count` = 2.
  - `locked` drops after 90. Feeding 91,92,93,94 relocks after 94.
- **Upstream clear:** while locked at 77, feed 0,1,2.
  - `restart` pulses once; `error` stays 0; `locked` stays 1.
- **Stalls and reset:**
  - With `sample_valid` toggling 1,0,0,1,… on 5,–,–,6,7,8,9, `locked` asserts after sample 9.
  - Asserting `clear` in the same cycle as valid sample 10 leaves `locked` 0, `err_count` 0, `expected` 1.
- **Saturation** (ERR_W=2): force 5 isolated single glitches while locked. `err_count` holds at 3 and `error` pulses 5 times.

Source files
------------

// File: rtl/count_seq_checker_if.sv
// Bus between a counter-sequence monitor and whoever drives and observes it.
// The checker takes the slave modport; a driver or bench takes the master modport.
interface count_seq_checker_if #(
  parameter int N     = 7,
  parameter int ERR_W = 8
);
  logic             sample_valid;
  logic [N:0]       count_in;
  logic             locked;
  logic [N:0]       expected;
  logic             error;
  logic             wrap;
  logic             restart;
  logic [ERR_W-1:0] err_count;

  modport master (
    output sample_valid, count_in,
    input  locked, expected, error, wrap, restart, err_count
  );

  modport slave (
    input  sample_valid, count_in,
    output locked, expected, error, wrap, restart, err_count
  );
endinterface

// File: rtl/count_seq_checker.sv
// Locks onto a +1 modulo 2^(N+1) count sequence, then flags discontinuities,
// telling legal wraps and upstream clears apart from real errors.
module count_seq_checker #(
  parameter int N          = 7,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 8
) (
  input  logic               clock,
  input  logic               clear,
  count_seq_checker_if.slave mon
);
  localparam int RUN_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT);
  localparam logic [RUN_W-1:0] LOCK_LAST = RUN_W'(LOCK_COUNT - 1);
  localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
  localparam logic [N:0]       ONE       = (N + 1)'(1);
  localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);

  typedef enum logic [1:0] {
    ST_ACQUIRE,
    ST_TRACK,
    ST_LOCKED
  } state_t;

  state_t           state_q, state_d;
  logic [N:0]       prev_q, prev_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             miss_q, miss_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             error_q, error_d;
  logic             wrap_q, wrap_d;
  logic             restart_q, restart_d;

  logic [N:0] predicted;
  logic       match;

  assign predicted = prev_q + ONE;
  assign match     = (mon.count_in == predicted);

  // NOTE: every variable gets its hold/idle value before the case so no path
  // leaves one unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    run_d       = run_q;
    miss_d      = miss_q;
    err_count_d = err_count_q;
    error_d     = 1'b0;
    wrap_d      = 1'b0;
    restart_d   = 1'b0;

    if (mon.sample_valid) begin
      prev_d = mon.count_in;
      unique case (state_q)
        ST_ACQUIRE: begin
          run_d   = '0;
          state_d = ST_TRACK;
        end
        ST_TRACK: begin
          if (!match) begin
            run_d = '0;
          end else if (run_q == LOCK_LAST) begin
            run_d   = '0;
            state_d = ST_LOCKED;
          end else begin
            run_d = run_q + RUN_ONE;
          end
        end
        ST_LOCKED: begin
          if (match) begin
            miss_d = 1'b0;
            wrap_d = &prev_q;
          end else if (mon.count_in == '0) begin
            // Non-max to zero is an upstream clear, not a fault.
            restart_d = 1'b1;
            miss_d    = 1'b0;
          end else begin
            error_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + ERR_ONE;
            if (miss_q) begin
              state_d = ST_TRACK;
              run_d   = '0;
              miss_d  = 1'b0;
            end else begin
              miss_d = 1'b1;
            end
          end
        end
        default: state_d = ST_ACQUIRE;
      endcase
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= ST_ACQUIRE;
      prev_q      <= '0;
      run_q       <= '0;
      miss_q      <= 1'b0;
      err_count_q <= '0;
      error_q     <= 1'b0;
      wrap_q      <= 1'b0;
      restart_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      err_count_q <= err_count_d;
      error_q     <= error_d;
      wrap_q      <= wrap_d;
      restart_q   <= restart_d;
    end
  end

  assign mon.locked    = (state_q == ST_LOCKED);
  assign mon.expected  = predicted;
  assign mon.error     = error_q;
  assign mon.wrap      = wrap_q;
  assign mon.restart   = restart_q;
  assign mon.err_count = err_count_q;
endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker: a default instance plus a 2-bit
// error-tally instance for saturation.
module tb_count_seq_checker;
  logic clock = 1'b0;
  logic clear = 1'b1;

  always #5 clock = ~clock;

  count_seq_checker_if #(.N(7), .ERR_W(8)) if_a ();
  count_seq_checker_if #(.N(7), .ERR_W(2)) if_b ();

  count_seq_checker #(.N(7), .LOCK_COUNT(4), .ERR_W(8)) dut (
    .clock (clock),
    .clear (clear),
    .mon   (if_a.slave)
  );

  count_seq_checker #(.N(7), .LOCK_COUNT(4), .ERR_W(2)) dut_sat (
    .clock (clock),
    .clear (clear),
    .mon   (if_b.slave)
  );

  int n_checks = 0;
  int n_bad    = 0;
  int wrap_seen, err_seen, restart_seen, err_b_seen;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample 1 time unit after the rise.
  task automatic step(input bit sel_b, input bit valid, input int value);
    @(negedge clock);
    if_a.sample_valid = valid && !sel_b;
    if_a.count_in     = 8'(value);
    if_b.sample_valid = valid && sel_b;
    if_b.count_in     = 8'(value);
    @(posedge clock);
    #1;
    wrap_seen    += int'(if_a.wrap);
    err_seen     += int'(if_a.error);
    restart_seen += int'(if_a.restart);
    err_b_seen   += int'(if_b.error);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1'b0, 1'b0, 0);
    clear = 1'b0;
    wrap_seen    = 0;
    err_seen     = 0;
    restart_seen = 0;
    err_b_seen   = 0;
  endtask

  task automatic feed(input bit sel_b, input int first, input int last);
    for (int v = first; v <= last; v++) step(sel_b, 1'b1, v);
  endtask

  initial begin
    if_a.sample_valid = 1'b0;
    if_a.count_in     = '0;
    if_b.sample_valid = 1'b0;
    if_b.count_in     = '0;
    do_clear();

    check("rst_locked", int'(if_a.locked), 0);
    check("rst_err_count", int'(if_a.err_count), 0);
    check("rst_expected", int'(if_a.expected), 1);
    check("rst_flags", int'({if_a.error, if_a.wrap, if_a.restart}), 0);

    // Lock and wrap: 250..255, 0, 1
    feed(1'b0, 250, 253);
    check("lock_not_yet", int'(if_a.locked), 0);
    step(1'b0, 1'b1, 254);
    check("lock_after_254", int'(if_a.locked), 1);
    feed(1'b0, 255, 255);
    step(1'b0, 1'b1, 0);
    check("wrap_pulse", int'(if_a.wrap), 1);
    step(1'b0, 1'b1, 1);
    check("wrap_gone", int'(if_a.wrap), 0);
    check("wrap_total", wrap_seen, 1);
    check("wrap_no_err", err_seen, 0);
    check("wrap_err_count", int'(if_a.err_count), 0);
    check("wrap_expected", int'(if_a.expected), 2);

    // Single glitch, then a second isolated glitch proves miss was cleared
    do_clear();
    feed(1'b0, 7, 11);
    check("g1_locked", int'(if_a.locked), 1);
    step(1'b0, 1'b1, 40);
    check("g1_error", int'(if_a.error), 1);
    check("g1_err_count", int'(if_a.err_count), 1);
    step(1'b0, 1'b1, 41);
    check("g1_error_gone", int'(if_a.error), 0);
    check("g1_still_locked", int'(if_a.locked), 1);
    step(1'b0, 1'b1, 60);
    check("g1_iso_locked", int'(if_a.locked), 1);
    check("g1_iso_err_count", int'(if_a.err_count), 2);

    // Double glitch drops lock, then relock on 91..94
    do_clear();
    feed(1'b0, 16, 20);
    step(1'b0, 1'b1, 50);
    check("g2_first_locked", int'(if_a.locked), 1);
    step(1'b0, 1'b1, 90);
    check("g2_unlocked", int'(if_a.locked), 0);
    check("g2_err_count", int'(if_a.err_count), 2);
    check("g2_err_pulses", err_seen, 2);
    feed(1'b0, 91, 93);
    check("g2_track_no_err", int'(if_a.error), 0);
    check("g2_relock_not_yet", int'(if_a.locked), 0);
    step(1'b0, 1'b1, 94);
    check("g2_relocked", int'(if_a.locked), 1);

    // Upstream clear
    do_clear();
    feed(1'b0, 73, 77);
    step(1'b0, 1'b1, 0);
    check("uc_restart", int'(if_a.restart), 1);
    check("uc_no_error", int'(if_a.error), 0);
    feed(1'b0, 1, 2);
    check("uc_restart_total", restart_seen, 1);
    check("uc_err_total", err_seen, 0);
    check("uc_locked", int'(if_a.locked), 1);
    check("uc_expected", int'(if_a.expected), 3);

    // Stalls hold state; garbage on the bus while invalid is ignored
    do_clear();
    step(1'b0, 1'b1, 5);
    step(1'b0, 1'b0, 200);
    step(1'b0, 1'b0, 13);
    feed(1'b0, 6, 7);
    step(1'b0, 1'b0, 99);
    step(1'b0, 1'b1, 8);
    check("stall_not_yet", int'(if_a.locked), 0);
    step(1'b0, 1'b1, 9);
    check("stall_locked", int'(if_a.locked), 1);
    step(1'b0, 1'b0, 77);
    check("stall_no_err", err_seen, 0);
    check("stall_expected", int'(if_a.expected), 10);

    // Clear wins over a same-cycle valid sample
    clear = 1'b1;
    step(1'b0, 1'b1, 10);
    clear = 1'b0;
    check("clr_locked", int'(if_a.locked), 0);
    check("clr_err_count", int'(if_a.err_count), 0);
    check("clr_expected", int'(if_a.expected), 1);

    // Saturation on the 2-bit tally instance
    do_clear();
    feed(1'b1, 0, 4);
    check("sat_locked", int'(if_b.locked), 1);
    step(1'b1, 1'b1, 100); step(1'b1, 1'b1, 101);
    step(1'b1, 1'b1, 150); step(1'b1, 1'b1, 151);
    step(1'b1, 1'b1, 30);  step(1'b1, 1'b1, 31);
    check("sat_at_max", int'(if_b.err_count), 3);
    step(1'b1, 1'b1, 60);
    check("sat_error_pulse", int'(if_b.error), 1);
    step(1'b1, 1'b1, 61);
    step(1'b1, 1'b1, 200); step(1'b1, 1'b1, 201);
    check("sat_err_count", int'(if_b.err_count), 3);
    check("sat_err_pulses", err_b_seen, 5);
    check("sat_still_locked", int'(if_b.locked), 1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
